uart_resp_tx: RTL and testbench
===============================

# uart_resp_tx

Serializes debug-port read responses back to the host over the UART TX line. It accepts the 42-bit response word `{1'b1, addr[8:0], data[31:0]}` produced by the instruction- or data-memory debug read path, together with its one-cycle ready pulse. It packs the word into bytes and shifts them out as 8N1 serial frames. It sits between the memory debug read ports (ready pulses ORed upstream) and the chip's `uart_tx` pad.

## Interface
- `CLKS_PER_BIT`, 434, clock cycles per UART bit (50 MHz / 115200); must be ≥ 2.
- `clk`  input  1  system clock
- `reset`  input  1  reset, asynchronous, active-high; clock clk.
- `resp_valid`  input  1  one-cycle pulse: `resp_data` holds a response to send
- `resp_data`  input  42  response word `{valid, addr[8:0], data[31:0]}`
- `tx`  output  1  UART serial line, idle high
- `busy`  output  1  high while a frame is being shifted or is pending
- `done`  output  1  one-cycle pulse when the last stop bit of a response completes
- `overrun`  output  1  one-cycle pulse when a response is dropped

## Operation
- Frame word: `{6'b0, resp_data}` is zero-extended to 48 bits and sent as 6 bytes, MSB byte first. Byte k is `word[47-8k -: 8]`.
- Byte format is 8N1:
  - start bit 0;
  - 8 data bits, LSB first;
  - stop bit 1.
- Each bit holds for exactly `CLKS_PER_BIT` cycles.
- Bytes are back-to-back: the next start bit follows the previous stop bit with no idle gap.
- FSM states:
  - IDLE → START on load.
  - START → DATA after 1 bit time.
  - DATA → STOP after 8 bit times.
  - STOP → START if bytes remain.
  - STOP → (last byte) START if the pending buffer is full, else IDLE.
- Counters:
  - `baud_cnt` runs 0..CLKS_PER_BIT-1, sized ceil(log2(CLKS_PER_BIT)).
  - `bit_idx` runs 0..7.
  - `byte_idx` runs 0..NBYTES-1.
  - All three wrap to 0 on state change.
- Buffering: one active shift register plus a one-entry pending register.
  - `resp_valid` in IDLE loads the active register directly.
  - `resp_valid` while active and the pending buffer is empty captures into pending.
  - `resp_valid` while active and the pending buffer is full drops the new word; `overrun` pulses for one cycle.
- Simultaneous events:
  - `resp_valid` in the same cycle the last stop bit ends with pending empty: the new word is loaded directly as the next active frame, with no gap.
  - Same case with pending full: pending is promoted and the new word is captured into pending; no overrun.
- `busy` is low only in IDLE with the pending buffer empty.

## Timing
- Reset values: `tx`=1, `busy`=0, `done`=0, `overrun`=0. The FSM is in IDLE with the pending buffer empty and all counters 0.
- Assertion of `reset` forces `tx` high immediately, mid-bit or mid-frame. The partial frame is abandoned; no resumption.
- `tx` is a registered output. `resp_valid` sampled at edge N gives `tx`=0 (start bit) from edge N+1.
- `busy` rises at edge N+1 along with the start bit.
- Frame length is NBYTES × 10 × `CLKS_PER_BIT` cycles: 60×CPB by default.
- `done` pulses in the cycle after the final stop bit's last count. `tx` stays 1 there.
- `busy` falls in the same cycle as `done` unless the pending buffer is full.

## Configuration
- `UART_RESP_SYNC_EN`
  - When defined: a sync byte 0xA5 is sent before the 6 data bytes, so NBYTES=7 and the frame is 70×CPB cycles.
  - When undefined: NBYTES=6 and no sync byte is sent.
- Buffering, handshake and timing rules are otherwise identical.

## Test plan
- CPB=4, sync off, `resp_data`=42'h205DEADBEEF pulsed once → `tx` carries bytes 02 05 DE AD BE EF (LSB first, 8N1, 4 cycles/bit). Start bit appears 1 cycle after the pulse. `done` pulses after 240 cycles; `busy` is high throughout.
- Same stimulus with `UART_RESP_SYNC_EN` → bytes A5 02 05 DE AD BE EF; `done` pulses after 280 cycles.
- Three pulses, at cycles 0, 10 and 20 (words A, B, C) → A then B sent back-to-back with no idle gap. C is dropped with `overrun` pulsing at cycle 20. Exactly two `done` pulses.
- `resp_valid` in the exact cycle `done` would fire, with pending empty → the next start bit follows immediately, with no idle bit and no overrun.
- Reset asserted mid-DATA of byte 3 → `tx`=1 at once, `busy`=0. A new `resp_valid` after reset release starts a clean frame from byte 0.
- Idle for 1000 cycles with no `resp_valid` → `tx` stays 1; `busy`, `done` and `overrun` stay 0.

Source files
------------

// File: rtl/uart_resp_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_resp_tx                                                 |
// | Description : Serializes 42-bit debug read responses onto the UART TX line |
// |               as 8N1 bytes, MSB byte first, with a one-entry pending       |
// |               buffer. Define UART_RESP_SYNC_EN to prefix every response    |
// |               with a 0xA5 sync byte (7 bytes per response instead of 6).   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_resp_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        resp_valid,
  input  logic [41:0] resp_data,
  output logic        tx,
  output logic        busy,
  output logic        done,
  output logic        overrun
);

`ifdef UART_RESP_SYNC_EN
  localparam int c_NBYTES = 7;
`else
  localparam int c_NBYTES = 6;
`endif
  localparam int c_WORD_W = c_NBYTES * 8;
  localparam int c_BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int c_BYTE_W = $clog2(c_NBYTES);

  localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [c_BAUD_W-1:0] c_BAUD_ONE  = c_BAUD_W'(1);
  localparam logic [c_BYTE_W-1:0] c_BYTE_LAST = c_BYTE_W'(c_NBYTES - 1);
  localparam logic [c_BYTE_W-1:0] c_BYTE_ONE  = c_BYTE_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // Build the on-wire word: optional sync byte, zero pad, response.
  function automatic logic [c_WORD_W-1:0] f_frame(input logic [41:0] d);
`ifdef UART_RESP_SYNC_EN
    return {8'hA5, 6'b0, d};
`else
    return {6'b0, d};
`endif
  endfunction

  state_t                r_state;
  logic [c_BAUD_W-1:0]   r_baud_cnt;
  logic [2:0]            r_bit_idx;
  logic [c_BYTE_W-1:0]   r_byte_idx;
  logic [c_WORD_W-1:0]   r_active;      // byte being sent is always the top byte
  logic                  r_pend_valid;
  logic [41:0]           r_pend_data;
  logic                  r_tx;
  logic                  r_done;

  state_t                w_state_next;
  logic [c_BAUD_W-1:0]   w_baud_next;
  logic [2:0]            w_bit_next;
  logic [c_BYTE_W-1:0]   w_byte_next;
  logic [c_WORD_W-1:0]   w_active_next;
  logic                  w_pend_valid_next;
  logic [41:0]           w_pend_data_next;
  logic                  w_tx_next;
  logic                  w_bit_end;
  logic                  w_last_end;
  logic                  w_overrun;
  logic [7:0]            w_cur_byte;

  // State register and datapath registers; reset drives the line idle at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_baud_cnt   <= '0;
      r_bit_idx    <= '0;
      r_byte_idx   <= '0;
      r_active     <= '0;
      r_pend_valid <= 1'b0;
      r_pend_data  <= '0;
      r_tx         <= 1'b1;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_baud_cnt   <= w_baud_next;
      r_bit_idx    <= w_bit_next;
      r_byte_idx   <= w_byte_next;
      r_active     <= w_active_next;
      r_pend_valid <= w_pend_valid_next;
      r_pend_data  <= w_pend_data_next;
      r_tx         <= w_tx_next;
      r_done       <= w_last_end;
    end
  end

  // Next-state, counter, buffer and line-level logic.
  always_comb begin
    w_state_next      = r_state;
    w_baud_next       = r_baud_cnt;
    w_bit_next        = r_bit_idx;
    w_byte_next       = r_byte_idx;
    w_active_next     = r_active;
    w_pend_valid_next = r_pend_valid;
    w_pend_data_next  = r_pend_data;
    w_overrun         = 1'b0;
    w_tx_next         = 1'b1;
    w_cur_byte        = 8'h00;
    w_bit_end         = (r_baud_cnt == c_BAUD_LAST);
    w_last_end        = (r_state == S_STOP) && w_bit_end && (r_byte_idx == c_BYTE_LAST);

    case (r_state)
      S_IDLE: begin
        if (resp_valid) begin
          w_state_next  = S_START;
          w_active_next = f_frame(resp_data);
          w_baud_next   = '0;
          w_bit_next    = '0;
          w_byte_next   = '0;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_next = S_DATA;
          w_baud_next  = '0;
        end else begin
          w_baud_next = r_baud_cnt + c_BAUD_ONE;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_baud_next = '0;
          if (r_bit_idx == 3'd7) begin
            w_state_next = S_STOP;
            w_bit_next   = '0;
          end else begin
            w_bit_next = r_bit_idx + 3'd1;
          end
        end else begin
          w_baud_next = r_baud_cnt + c_BAUD_ONE;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_baud_next = '0;
          if (r_byte_idx != c_BYTE_LAST) begin
            w_state_next  = S_START;
            w_byte_next   = r_byte_idx + c_BYTE_ONE;
            w_active_next = r_active << 8;
          end else begin
            w_byte_next = '0;
            if (r_pend_valid) begin
              // Promote pending; a word arriving now refills pending, no drop.
              w_state_next      = S_START;
              w_active_next     = f_frame(r_pend_data);
              w_pend_valid_next = resp_valid;
              if (resp_valid) begin
                w_pend_data_next = resp_data;
              end
            end else if (resp_valid) begin
              // Arrival on the final count chains straight into a new frame.
              w_state_next  = S_START;
              w_active_next = f_frame(resp_data);
            end else begin
              w_state_next = S_IDLE;
            end
          end
        end else begin
          w_baud_next = r_baud_cnt + c_BAUD_ONE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // Arrivals mid-frame go to pending, or are dropped if pending is occupied.
    if (resp_valid && (r_state != S_IDLE) && !w_last_end) begin
      if (!r_pend_valid) begin
        w_pend_valid_next = 1'b1;
        w_pend_data_next  = resp_data;
      end else begin
        w_overrun = 1'b1;
      end
    end

    w_cur_byte = w_active_next[c_WORD_W-1 -: 8];
    case (w_state_next)
      S_START: w_tx_next = 1'b0;
      S_DATA:  w_tx_next = w_cur_byte[w_bit_next];
      default: w_tx_next = 1'b1;
    endcase
  end

  assign tx      = r_tx;
  assign done    = r_done;
  assign overrun = w_overrun;
  assign busy    = (r_state != S_IDLE) || r_pend_valid;

endmodule
`default_nettype wire

// File: tb/tb_uart_resp_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_resp_tx                                              |
// | Description : Self-checking bench for uart_resp_tx. A cycle-exact 8N1      |
// |               receiver decodes tx and checks each byte against a queue of  |
// |               expected bytes filled when responses are issued. Honours     |
// |               UART_RESP_SYNC_EN for the sync-byte build.                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_uart_resp_tx;

  localparam int CPB = 4;
`ifdef UART_RESP_SYNC_EN
  localparam int NB = 7;
`else
  localparam int NB = 6;
`endif
  localparam int FRAME = NB * 10 * CPB;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        resp_valid = 1'b0;
  logic [41:0] resp_data = '0;
  logic        tx;
  logic        busy;
  logic        done;
  logic        overrun;

  int n_vec  = 0;
  int n_err  = 0;
  int n_done = 0;
  int n_ovr  = 0;

  logic [7:0] exp_q[$];

  uart_resp_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .reset     (reset),
    .resp_valid(resp_valid),
    .resp_data (resp_data),
    .tx        (tx),
    .busy      (busy),
    .done      (done),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_word(input logic [41:0] d);
    logic [47:0] w;
    w = {6'b0, d};
`ifdef UART_RESP_SYNC_EN
    exp_q.push_back(8'hA5);
`endif
    for (int k = 0; k < 6; k++) exp_q.push_back(w[47-8*k -: 8]);
  endtask

  // Drive a one-cycle response pulse; returns at the next falling edge.
  task automatic pulse(input logic [41:0] d);
    resp_valid = 1'b1;
    resp_data  = d;
    push_word(d);
    @(negedge clk);
    resp_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int n, output bit busy_dropped);
    n = 0;
    busy_dropped = 1'b0;
    do begin
      @(negedge clk);
      #1;
      n++;
      if (done !== 1'b1 && busy !== 1'b1) busy_dropped = 1'b1;
    end while (done !== 1'b1 && n < limit);
    check("done_seen", done, 1);
  endtask

  // Serial receiver and pulse counters, sampled mid-cycle.
  logic       rx_on = 1'b0;
  int         rx_pos = 0;
  logic [7:0] rx_byte = '0;
  always begin
    @(negedge clk);
    #2;
    if (done === 1'b1) n_done++;
    if (overrun === 1'b1) n_ovr++;
    if (reset) begin
      rx_on = 1'b0;
    end else begin
      if (!rx_on) begin
        if (tx === 1'b0) begin
          rx_on  = 1'b1;
          rx_pos = 0;
        end
      end else begin
        rx_pos++;
      end
      if (rx_on) begin
        if (rx_pos % CPB == CPB / 2) begin
          if (rx_pos / CPB == 0) begin
            check("start_bit", tx, 0);
          end else if (rx_pos / CPB <= 8) begin
            rx_byte[rx_pos/CPB-1] = tx;
          end else begin
            check("stop_bit", tx, 1);
            if (exp_q.size() == 0) check("rx_extra_byte", {1'b1, rx_byte}, 0);
            else check("rx_byte", rx_byte, exp_q.pop_front());
          end
        end
        if (rx_pos == 10 * CPB - 1) rx_on = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no end, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    bit bd;
    int d0;
    int o0;
    logic [7:0] b3;

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_overrun", overrun, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single response
    d0 = n_done;
    pulse(42'h205DEADBEEF);
    #1;
    check("t1_start_tx", tx, 0);
    check("t1_busy_rise", busy, 1);
    wait_done(FRAME + 20, n, bd);
    check("t1_done_after_start", n, FRAME);
    check("t1_busy_held", bd, 0);
    check("t1_tx_at_done", tx, 1);
    check("t1_busy_at_done", busy, 0);
    @(negedge clk);
    #1;
    check("t1_done_one_cycle", done, 0);
    check("t1_done_count", n_done - d0, 1);
    repeat (4) @(negedge clk);

    // Three pulses: A sent, B pending, C dropped
    d0 = n_done;
    o0 = n_ovr;
    pulse(42'h3FF_0123_4567);
    repeat (9) @(negedge clk);
    pulse(42'h0AA_89AB_CDEF);
    repeat (9) @(negedge clk);
    resp_valid = 1'b1;
    resp_data  = 42'h155_5555_AAAA;
    #1;
    check("t3_overrun", overrun, 1);
    check("t3_busy", busy, 1);
    @(negedge clk);
    resp_valid = 1'b0;
    wait_done(FRAME + 10, n, bd);
    check("t3_first_done", n, FRAME - 20);
    check("t3_busy_kept", busy, 1);
    check("t3_no_gap_tx", tx, 0);
    wait_done(FRAME + 10, n, bd);
    check("t3_second_done", n, FRAME);
    check("t3_busy_held", bd, 0);
    check("t3_busy_at_done", busy, 0);
    repeat (5) @(negedge clk);
    check("t3_done_count", n_done - d0, 2);
    check("t3_overrun_count", n_ovr - o0, 1);

    // Arrival on the final stop count with pending empty
    d0 = n_done;
    o0 = n_ovr;
    pulse(42'h1C3_F00D_CAFE);
    repeat (FRAME - 1) @(negedge clk);
    resp_valid = 1'b1;
    resp_data  = 42'h07E_1234_8001;
    push_word(42'h07E_1234_8001);
    @(negedge clk);
    resp_valid = 1'b0;
    #1;
    check("t4_done", done, 1);
    check("t4_tx_start", tx, 0);
    check("t4_busy", busy, 1);
    wait_done(FRAME + 10, n, bd);
    check("t4_second_done", n, FRAME);
    check("t4_busy_held", bd, 0);
    repeat (3) @(negedge clk);
    check("t4_no_overrun", n_ovr - o0, 0);
    check("t4_done_count", n_done - d0, 2);

    // Reset mid-data of byte 3
    d0 = n_done;
    b3 = (NB == 7) ? 8'hDE : 8'hAD;
    pulse(42'h205DEADBEEF);
    repeat (129) @(negedge clk);
    #1;
    check("t5_pre_tx", tx, b3[1]);
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("t5_tx_forced", tx, 1);
    check("t5_busy_clear", busy, 0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    pulse(42'h2C4_1357_9BDF);
    #1;
    check("t5_restart_tx", tx, 0);
    wait_done(FRAME + 10, n, bd);
    check("t5_clean_frame", n, FRAME);
    repeat (3) @(negedge clk);
    check("t5_done_count", n_done - d0, 1);

    // Long idle
    begin
      bit quiet_bad;
      quiet_bad = 1'b0;
      for (int i = 0; i < 1000; i++) begin
        @(negedge clk);
        #1;
        if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || overrun !== 1'b0) quiet_bad = 1'b1;
      end
      check("t6_idle_quiet", quiet_bad, 0);
    end

    check("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
